// File: rtl/multiphase_clkgen.sv
`timescale 1ns/1ps
// multiphase_clkgen
//
// Derives NPHASE non-overlapping phase clocks from one master clock. Each
// phase is held high for HIGH_CYC cycles. It is followed by GAP_CYC cycles
// with every phase low. Phases run in order 0..NPHASE-1, and that order
// repeats while enable is held. An optional period limit stops generation
// and raises a sticky done flag.
//
// Ports
//   clk          master clock, rising edge
//   reset        synchronous, active-high
//   enable       run request; a stop only takes effect at the end of a GAP
//   phi          registered phase clocks, at most one bit high at a time
//   period_tick  one-cycle pulse on the final GAP cycle of the last phase
//   period_cnt   number of completed periods (wraps at 2^32)
//   busy         FSM is in HIGH or GAP
//   done         sticky, set when MAX_PERIODS periods have completed
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | all phases low, waiting for enable (blocked while done=1)
// HIGH  | phi[idx] high, cnt counts down the high time
// GAP   | all phases low, cnt counts down the dead time
module multiphase_clkgen #(
    parameter int NPHASE      = 2,
    parameter int HIGH_CYC    = 4,
    parameter int GAP_CYC     = 1,
    parameter int MAX_PERIODS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [NPHASE-1:0] phi,
    output logic              period_tick,
    output logic [31:0]       period_cnt,
    output logic              busy,
    output logic              done
);

    localparam int MAXC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NPHASE);

    localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(NPHASE - 1);
    localparam logic [NPHASE-1:0] PHI0      = NPHASE'(1);
    localparam logic [31:0]       MAX_P     = 32'(MAX_PERIODS);
    localparam logic              GAP_ONE   = (GAP_CYC == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;

    logic            last_phase;
    logic [IW-1:0]   nxt_idx;
    logic [31:0]     period_next;
    logic            limit_hit;

    assign last_phase  = (idx == LAST_IDX);
    assign nxt_idx     = last_phase ? '0 : idx + IW'(1);
    assign period_next = period_cnt + 32'd1;
    // Only meaningful when the period is closing; MAX_P=0 means unlimited.
    assign limit_hit   = (MAX_P != 32'd0) && (period_next == MAX_P);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            phi         <= '0;
            period_tick <= 1'b0;
            period_cnt  <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !done) begin
                        state <= HIGH;
                        idx   <= '0;
                        cnt   <= HIGH_LOAD;
                        phi   <= PHI0;
                        busy  <= 1'b1;
                    end
                end

                HIGH: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                        phi   <= '0;
                        // A single-cycle gap is itself the last cycle of the period.
                        period_tick <= last_phase && GAP_ONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        // Registered tick: raise it for the cycle where cnt will be 0.
                        period_tick <= last_phase && (cnt == CW'(1));
                    end else begin
                        if (last_phase) begin
                            period_cnt <= period_next;
                        end
                        if (last_phase && limit_hit) begin
                            state <= IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!enable) begin
                            state <= IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= HIGH;
                            idx   <= nxt_idx;
                            cnt   <= HIGH_LOAD;
                            phi   <= PHI0 << nxt_idx;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    cnt   <= '0;
                    phi   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiphase_clkgen.sv
`timescale 1ns/1ps
// Directed bench for multiphase_clkgen.
// Three instances share clk/reset: defaults, a 4-phase 2/2 variant and a
// MAX_PERIODS=3 variant; each has its own enable. Cycle n is the interval
// after rising edge n; edge 1 is the first to sample enable. Outputs are
// sampled on the falling edge.
module tb_multiphase_clkgen;

    logic clk = 1'b0;
    logic reset;
    logic en_d, en_4, en_m;

    logic [1:0]  phi_d;
    logic        tick_d, busy_d, done_d;
    logic [31:0] pcnt_d;

    logic [3:0]  phi_4;
    logic        tick_4, busy_4, done_4;
    logic [31:0] pcnt_4;

    logic [1:0]  phi_m;
    logic        tick_m, busy_m, done_m;
    logic [31:0] pcnt_m;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    multiphase_clkgen u_def (
        .clk(clk), .reset(reset), .enable(en_d),
        .phi(phi_d), .period_tick(tick_d), .period_cnt(pcnt_d),
        .busy(busy_d), .done(done_d)
    );

    multiphase_clkgen #(.NPHASE(4), .HIGH_CYC(2), .GAP_CYC(2)) u_p4 (
        .clk(clk), .reset(reset), .enable(en_4),
        .phi(phi_4), .period_tick(tick_4), .period_cnt(pcnt_4),
        .busy(busy_4), .done(done_4)
    );

    multiphase_clkgen #(.MAX_PERIODS(3)) u_max (
        .clk(clk), .reset(reset), .enable(en_m),
        .phi(phi_m), .period_tick(tick_m), .period_cnt(pcnt_m),
        .busy(busy_m), .done(done_m)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at a falling edge in cycle 0 with reset released.
    task automatic start_run();
        reset = 1'b1;
        en_d  = 1'b0;
        en_4  = 1'b0;
        en_m  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Defaults: 01 x4, gap, 10 x4, gap (tick), repeating every 10 cycles.
    function automatic logic [1:0] exp_phi_d(input int c);
        int pos;
        pos = (c - 1) % 10;
        if (pos < 4) return 2'b01;
        if (pos == 4) return 2'b00;
        if (pos < 9) return 2'b10;
        return 2'b00;
    endfunction

    // 4 phases, 2 high + 2 gap each, 16-cycle period.
    function automatic logic [3:0] exp_phi_4(input int c);
        int pos;
        pos = (c - 1) % 16;
        if ((pos % 4) < 2) return 4'(1 << (pos / 4));
        return 4'b0000;
    endfunction

    initial begin
        // Reset state
        start_run();
        check("reset_state_def", {phi_d, tick_d, busy_d, done_d, pcnt_d}, 64'd0);
        check("reset_state_p4",  {phi_4, tick_4, busy_4, done_4, pcnt_4}, 64'd0);
        check("reset_state_max", {phi_m, tick_m, busy_m, done_m, pcnt_m}, 64'd0);

        // Defaults, free-running for 100 periods
        en_d = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            step();
            check("free_phi", phi_d, exp_phi_d(c));
            check("free_onehot0", $onehot0(phi_d), 1);
            check("free_tick", tick_d, ((c - 1) % 10) == 9);
            if (c == 1)  check("free_busy_start", busy_d, 1);
            if (c == 11) check("free_pcnt_1", pcnt_d, 1);
        end
        step();
        check("free_pcnt_100", pcnt_d, 100);
        check("free_phi_1001", phi_d, 2'b01);
        check("free_done", done_d, 0);
        reset = 1'b1;
        step();
        check("free_reset_clear", {phi_d, tick_d, busy_d, done_d, pcnt_d}, 64'd0);

        // 4-phase, 2 high / 2 gap
        start_run();
        en_4 = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            step();
            check("p4_phi", phi_4, exp_phi_4(c));
            check("p4_tick", tick_4, ((c - 1) % 16) == 15);
            if (c == 16) check("p4_pcnt_0", pcnt_4, 0);
            if (c == 17) check("p4_pcnt_1", pcnt_4, 1);
            if (c == 33) check("p4_pcnt_2", pcnt_4, 2);
        end

        // Mid-phase stop during phi[1]
        start_run();
        en_d = 1'b1;
        repeat (7) step();
        en_d = 1'b0;
        step();
        check("mid_phi_c8", phi_d, 2'b10);
        step();
        check("mid_phi_c9", phi_d, 2'b10);
        step();
        check("mid_c10", {phi_d, tick_d, busy_d}, {2'b00, 1'b1, 1'b1});
        step();
        check("mid_c11", {phi_d, tick_d, busy_d, pcnt_d}, {2'b00, 1'b0, 1'b0, 32'd1});
        step();
        check("mid_c12_idle", {phi_d, busy_d}, 3'b000);
        en_d = 1'b1;
        step();
        check("mid_restart", {phi_d, busy_d}, {2'b01, 1'b1});

        // Stop after phase 0
        start_run();
        en_d = 1'b1;
        repeat (2) step();
        en_d = 1'b0;
        for (int c = 3; c <= 15; c++) begin
            step();
            check("stop0_phi", phi_d, (c <= 4) ? 2'b01 : 2'b00);
            check("stop0_busy", busy_d, c <= 5);
            check("stop0_tick_pcnt", {tick_d, pcnt_d}, 33'd0);
        end

        // Reset mid-operation
        start_run();
        en_d = 1'b1;
        repeat (7) step();
        check("rst_pre_phi", phi_d, 2'b10);
        reset = 1'b1;
        step();
        check("rst_clear", {phi_d, tick_d, busy_d, done_d, pcnt_d}, 64'd0);
        reset = 1'b0;
        step();
        check("rst_restart", {phi_d, busy_d}, {2'b01, 1'b1});

        // MAX_PERIODS=3
        start_run();
        en_m = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            check("max_phi", phi_m, exp_phi_d(c));
            check("max_done_low", done_m, 0);
        end
        check("max_tick_c30", tick_m, 1);
        step();
        check("max_c31", {phi_m, busy_m, done_m, pcnt_m}, {2'b00, 1'b0, 1'b1, 32'd3});
        for (int c = 32; c <= 51; c++) begin
            step();
            check("max_hold", {phi_m, busy_m, done_m, tick_m}, {2'b00, 1'b0, 1'b1, 1'b0});
        end
        reset = 1'b1;
        step();
        check("max_reset_clear", {done_m, pcnt_m}, 33'd0);
        reset = 1'b0;
        step();
        check("max_restart", {phi_m, busy_m, done_m}, {2'b01, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
